// File: rtl/kernel_pr_wb_pkg.sv
// Shared types and constants for the PageRank write-back burst engine.
package kernel_pr_wb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    REQ,
    DATA,
    DRAIN
  } wb_state_e;

  localparam int LEN_WIDTH      = 8;
  localparam int BYTES_PER_BEAT = 4;

endpackage

// File: rtl/kernel_pr_write_back_burst_buf.sv
// Single-clock burst staging buffer: values are written in arrival order and
// read back in the same order; clear rewinds both pointers for the next burst.
module kernel_pr_write_back_burst_buf
  import kernel_pr_wb_pkg::*;
#(
  parameter int DATA_WIDTH = 8 * BYTES_PER_BEAT,
  parameter int DEPTH      = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clr_i,
  input  logic                  wr_en_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  rd_en_i,
  output logic [DATA_WIDTH-1:0] rd_data_o
);

  localparam int PW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]         wr_ptr_q;
  logic [PW-1:0]         rd_ptr_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (wr_en_i) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (rd_en_i) rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

  // Storage holds payload only, so it carries no reset.
  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_ptr_q];

endmodule

// File: rtl/kernel_pr_write_back_burst.sv
// Write-back burst engine: drains PR values per start token into bursts and
// tracks responses. Optional checksum output under KERNEL_PR_WB_CHECKSUM_EN.
module kernel_pr_write_back_burst
  import kernel_pr_wb_pkg::*;
#(
  parameter int DATA_WIDTH      = 8 * BYTES_PER_BEAT,
  parameter int ADDR_WIDTH      = 64,
  parameter int BURST_LEN       = 16,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start_empty_n,
  output logic                  start_read,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [31:0]           num_vertices,
  input  logic                  pr_empty_n,
  output logic                  pr_read,
  input  logic [DATA_WIDTH-1:0] pr_dout,
  output logic                  wr_req_valid,
  input  logic                  wr_req_ready,
  output logic [ADDR_WIDTH-1:0] wr_req_addr,
  output logic [LEN_WIDTH-1:0]  wr_req_len,
  output logic                  wr_data_valid,
  input  logic                  wr_data_ready,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_data_last,
  input  logic                  wr_resp_valid,
`ifdef KERNEL_PR_WB_CHECKSUM_EN
  output logic [DATA_WIDTH-1:0] checksum,
`endif
  output logic                  done,
  output logic                  busy
);

  localparam int CW         = $clog2(BURST_LEN) + 1;
  localparam int OW         = $clog2(MAX_OUTSTANDING + 1);
  localparam int BEAT_BYTES = DATA_WIDTH / 8;

  wb_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
  logic [31:0]           remaining_q, remaining_d;
  logic [CW-1:0]         fill_cnt_q, fill_cnt_d;
  logic [CW-1:0]         beat_cnt_q, beat_cnt_d;
  logic [OW-1:0]         out_q, out_d;
  logic [CW-1:0]         burst_cnt;
  logic [DATA_WIDTH-1:0] buf_rd_data;
  logic                  req_fire, beat_fire, last_fire, resp_take, buf_clr;

  assign burst_cnt = (remaining_q < 32'(BURST_LEN)) ? remaining_q[CW-1:0] : CW'(BURST_LEN);
  assign req_fire  = wr_req_valid & wr_req_ready;
  assign beat_fire = wr_data_valid & wr_data_ready;
  assign last_fire = beat_fire & wr_data_last;
  assign buf_clr   = start_read | last_fire;
  assign busy      = (state_q != IDLE);

  kernel_pr_write_back_burst_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (BURST_LEN)
  ) u_buf (
    .clk       (clk),
    .reset_n   (reset_n),
    .clr_i     (buf_clr),
    .wr_en_i   (pr_read),
    .wr_data_i (pr_dout),
    .rd_en_i   (beat_fire),
    .rd_data_o (buf_rd_data)
  );

  // Payload outputs are forced to zero outside their state so that reset
  // (which parks the FSM in IDLE) drives every output low.
  always_comb begin
    state_d       = state_q;
    cur_addr_d    = cur_addr_q;
    remaining_d   = remaining_q;
    fill_cnt_d    = fill_cnt_q;
    beat_cnt_d    = beat_cnt_q;
    start_read    = 1'b0;
    pr_read       = 1'b0;
    wr_req_valid  = 1'b0;
    wr_req_addr   = '0;
    wr_req_len    = '0;
    wr_data_valid = 1'b0;
    wr_data       = '0;
    wr_data_last  = 1'b0;
    done          = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_empty_n && reset_n) begin
          start_read  = 1'b1;
          cur_addr_d  = base_addr;
          remaining_d = num_vertices;
          fill_cnt_d  = '0;
          beat_cnt_d  = '0;
          state_d     = (num_vertices == 32'd0) ? DRAIN : FILL;
        end
      end
      FILL: begin
        if (pr_empty_n) begin
          pr_read = 1'b1;
          if (fill_cnt_q + CW'(1) == burst_cnt) begin
            fill_cnt_d = '0;
            state_d    = REQ;
          end else begin
            fill_cnt_d = fill_cnt_q + CW'(1);
          end
        end
      end
      REQ: begin
        wr_req_valid = (out_q < OW'(MAX_OUTSTANDING));
        wr_req_addr  = cur_addr_q;
        wr_req_len   = LEN_WIDTH'(burst_cnt - CW'(1));
        if (wr_req_valid && wr_req_ready) state_d = DATA;
      end
      DATA: begin
        wr_data_valid = 1'b1;
        wr_data       = buf_rd_data;
        wr_data_last  = (beat_cnt_q == burst_cnt - CW'(1));
        if (wr_data_ready) begin
          if (wr_data_last) begin
            beat_cnt_d  = '0;
            cur_addr_d  = cur_addr_q + ADDR_WIDTH'(burst_cnt) * ADDR_WIDTH'(BEAT_BYTES);
            remaining_d = remaining_q - 32'(burst_cnt);
            state_d     = (remaining_q == 32'(burst_cnt)) ? DRAIN : FILL;
          end else begin
            beat_cnt_d = beat_cnt_q + CW'(1);
          end
        end
      end
      DRAIN: begin
        if (out_q == '0) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A response coinciding with a request accept cancels it out, even from zero.
  assign resp_take = wr_resp_valid & ((out_q != '0) | req_fire);

  always_comb begin
    out_d = out_q;
    if (req_fire && !resp_take)      out_d = out_q + OW'(1);
    else if (resp_take && !req_fire) out_d = out_q - OW'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cur_addr_q  <= '0;
      remaining_q <= '0;
      fill_cnt_q  <= '0;
      beat_cnt_q  <= '0;
      out_q       <= '0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      remaining_q <= remaining_d;
      fill_cnt_q  <= fill_cnt_d;
      beat_cnt_q  <= beat_cnt_d;
      out_q       <= out_d;
    end
  end

`ifdef KERNEL_PR_WB_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] checksum_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)       checksum_q <= '0;
    else if (start_read) checksum_q <= '0;
    else if (beat_fire)  checksum_q <= checksum_q + wr_data;
  end

  assign checksum = checksum_q;
`else
  // Checksum port and accumulator are absent in this build.
`endif

endmodule

// File: tb/tb_kernel_pr_write_back_burst.sv
// Randomized self-checking bench for kernel_pr_write_back_burst with a
// burst-level reference model built from num_vertices and base_addr.
module tb_kernel_pr_write_back_burst;

  localparam int DW = 32;
  localparam int AW = 64;
  localparam int BL = 16;
  localparam int MO = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n, start_empty_n, start_read, pr_empty_n, pr_read;
  logic [AW-1:0] base_addr, wr_req_addr;
  logic [31:0]   num_vertices;
  logic [DW-1:0] pr_dout, wr_data;
  logic          wr_req_valid, wr_req_ready, wr_data_valid, wr_data_ready;
  logic [7:0]    wr_req_len;
  logic          wr_data_last, wr_resp_valid, done, busy;
`ifdef KERNEL_PR_WB_CHECKSUM_EN
  logic [DW-1:0] checksum;
`endif

  kernel_pr_write_back_burst #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BURST_LEN(BL), .MAX_OUTSTANDING(MO)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .start_empty_n(start_empty_n), .start_read(start_read),
    .base_addr(base_addr), .num_vertices(num_vertices),
    .pr_empty_n(pr_empty_n), .pr_read(pr_read), .pr_dout(pr_dout),
    .wr_req_valid(wr_req_valid), .wr_req_ready(wr_req_ready),
    .wr_req_addr(wr_req_addr), .wr_req_len(wr_req_len),
    .wr_data_valid(wr_data_valid), .wr_data_ready(wr_data_ready),
    .wr_data(wr_data), .wr_data_last(wr_data_last),
    .wr_resp_valid(wr_resp_valid),
`ifdef KERNEL_PR_WB_CHECKSUM_EN
    .checksum(checksum),
`endif
    .done(done), .busy(busy)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Environment state shared by driver, monitor and sequence.
  bit            tok_avail = 0;
  logic [AW-1:0] tok_base  = '0;
  logic [31:0]   tok_num   = '0;
  logic [DW-1:0] pr_src[$];
  bit            gaps = 0, hold_resp = 0, pop_pr = 0, pop_tok = 0;
  int            resp_owed = 0, req_cnt = 0, resp_cnt = 0, done_cnt = 0, start_cnt = 0;
  int            cyc = 0, pop_cyc = 0, first_req_cyc = -1;
  logic [71:0]   got_req[$], exp_req[$];
  logic [32:0]   got_beat[$], exp_beat[$];
  logic [DW-1:0] exp_sum;
  bit            req_stall = 0, dat_stall = 0;
  logic [71:0]   prev_req;
  logic [32:0]   prev_dat;

  task automatic drive();
    if (pop_pr) begin void'(pr_src.pop_front()); pop_pr = 0; end
    if (pop_tok) begin tok_avail = 0; pop_tok = 0; end
    start_empty_n = tok_avail;
    base_addr     = tok_base;
    num_vertices  = tok_num;
    pr_empty_n    = (pr_src.size() > 0) && (!gaps || $urandom_range(0, 3) != 0);
    pr_dout       = (pr_src.size() > 0) ? pr_src[0] : $urandom;
    wr_req_ready  = !gaps || $urandom_range(0, 2) != 0;
    wr_data_ready = !gaps || $urandom_range(0, 2) != 0;
    wr_resp_valid = 1'b0;
    if (!hold_resp && resp_owed > 0 && (!gaps || $urandom_range(0, 1) == 1)) begin
      wr_resp_valid = 1'b1;
      resp_owed--;
    end
  endtask

  initial forever begin
    @(posedge clk);
    #1 drive();
  end

  initial forever begin
    @(negedge clk);
    cyc++;
    if (reset_n) begin
      if (start_read) begin
        check_val("start_read_needs_token", start_empty_n, 1);
        start_cnt++; pop_tok = 1; pop_cyc = cyc; first_req_cyc = -1;
      end
      if (pr_read) begin
        check_val("pr_read_needs_data", pr_empty_n, 1);
        pop_pr = 1;
      end
      if (wr_req_valid) begin
        if (first_req_cyc < 0) first_req_cyc = cyc;
        check_val("outstanding_limit", (req_cnt - resp_cnt) < MO, 1);
      end
      if (req_stall) check_val("req_stable", {wr_req_valid, wr_req_addr, wr_req_len}, {1'b1, prev_req});
      if (dat_stall) check_val("beat_stable", {wr_data_valid, wr_data_last, wr_data}, {1'b1, prev_dat});
      if (done) check_val("done_with_zero_outstanding", req_cnt - resp_cnt, 0);
      req_stall = wr_req_valid && !wr_req_ready;
      prev_req  = {wr_req_addr, wr_req_len};
      dat_stall = wr_data_valid && !wr_data_ready;
      prev_dat  = {wr_data_last, wr_data};
      if (wr_req_valid && wr_req_ready) begin
        got_req.push_back({wr_req_addr, wr_req_len});
        req_cnt++;
      end
      if (wr_data_valid && wr_data_ready) begin
        got_beat.push_back({wr_data_last, wr_data});
        if (wr_data_last) resp_owed++;
      end
      if (wr_resp_valid) resp_cnt++;
      if (done) done_cnt++;
    end
  end

  // Reference model: split the job into BL-sized bursts with plain arithmetic.
  task automatic start_job(input logic [AW-1:0] base, input int num, input bit seq);
    logic [DW-1:0] vals[$];
    int len;
    exp_req.delete(); exp_beat.delete(); got_req.delete(); got_beat.delete();
    exp_sum = '0;
    for (int i = 0; i < num; i++) begin
      vals.push_back(seq ? DW'(i + 1) : DW'($urandom));
      pr_src.push_back(vals[i]);
      exp_sum += vals[i];
    end
    for (int off = 0; off < num; off += BL) begin
      len = (num - off < BL) ? num - off : BL;
      exp_req.push_back({base + AW'(off) * AW'(DW / 8), 8'(len - 1)});
      for (int j = 0; j < len; j++) exp_beat.push_back({j == len - 1, vals[off + j]});
    end
    start_cnt = 0;
    tok_base  = base;
    tok_num   = num;
    tok_avail = 1;
  endtask

  task automatic finish_job(input string name, input int num);
    int d0, bc;
    d0 = done_cnt;
    for (int t = 0; t < 4000 && done_cnt == d0; t++) @(posedge clk);
    check_val({name, "_done_seen"}, done_cnt - d0, 1);
`ifdef KERNEL_PR_WB_CHECKSUM_EN
    check_val({name, "_checksum_at_done"}, checksum, exp_sum);
`endif
    repeat (3) @(posedge clk);
    check_val({name, "_single_done"}, done_cnt - d0, 1);
    check_val({name, "_single_pop"}, start_cnt, 1);
    check_val({name, "_busy_low"}, busy, 0);
    check_val({name, "_req_count"}, got_req.size(), exp_req.size());
    for (int i = 0; i < exp_req.size() && i < got_req.size(); i++)
      check_val({name, "_req"}, got_req[i], exp_req[i]);
    check_val({name, "_beat_count"}, got_beat.size(), exp_beat.size());
    for (int i = 0; i < exp_beat.size() && i < got_beat.size(); i++)
      check_val({name, "_beat"}, got_beat[i], exp_beat[i]);
    if (num > 0) begin
      bc = (num < BL) ? num : BL;
      check_val({name, "_first_req_latency"}, (first_req_cyc - pop_cyc) >= (1 + bc), 1);
    end
`ifdef KERNEL_PR_WB_CHECKSUM_EN
    check_val({name, "_checksum_stable"}, checksum, exp_sum);
`endif
  endtask

  initial begin
    reset_n       = 1'b0;
    tok_avail     = 1;
    tok_num       = 32'd5;
    start_empty_n = 1'b1; pr_empty_n = 1'b0; pr_dout = '0; base_addr = '0; num_vertices = '0;
    wr_req_ready  = 1'b0; wr_data_ready = 1'b0; wr_resp_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_val("reset_outputs_zero",
              {start_read, pr_read, wr_req_valid, wr_req_addr, wr_req_len, wr_data_valid,
               wr_data, wr_data_last, done, busy}, '0);
    tok_avail = 0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);

    start_job(64'h0, 0, 0);
    finish_job("zero_vertices", 0);

    start_job(64'h1000, 40, 1);
    finish_job("forty_vertices", 40);

    hold_resp = 1;
    start_job(64'h8000, 100, 0);
    repeat (250) @(posedge clk);
    check_val("held_req_count", got_req.size(), MO);
    @(negedge clk);
    check_val("held_req_valid_low", wr_req_valid, 0);
    hold_resp = 0;
    finish_job("held_responses", 100);

    gaps = 1;
    for (int k = 0; k < 6; k++) begin
      logic [AW-1:0] b;
      b = (k == 0) ? 64'hFFFF_FFFF_FFFF_FFC0 : {$urandom, $urandom & 32'hFFFF_FFFC};
      start_job(b, $urandom_range(1, 70), 0);
      finish_job("random_job", int'(tok_num));
    end

    start_job(64'h4000, 40, 0);
    for (int t = 0; t < 800 && !wr_data_valid; t++) @(negedge clk);
    check_val("reached_data_state", wr_data_valid, 1);
    #2 reset_n = 1'b0;
    #1 check_val("reset_mid_data_outputs_zero",
                 {start_read, pr_read, wr_req_valid, wr_req_addr, wr_req_len, wr_data_valid,
                  wr_data, wr_data_last, done, busy}, '0);
    repeat (2) @(posedge clk);
    tok_avail = 0; pr_src.delete(); resp_owed = 0; pop_pr = 0; pop_tok = 0;
    req_cnt = 0; resp_cnt = 0; req_stall = 0; dat_stall = 0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    start_job(64'h2000, 1, 0);
    finish_job("after_reset_single", 1);

`ifdef KERNEL_PR_WB_CHECKSUM_EN
    start_job(64'h3000, 10, 1);
    finish_job("checksum_1_to_10", 10);
    check_val("checksum_equals_55", checksum, 55);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
